// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART frame loader: sync marker default,
// FSM state encoding and the error codes reported on err_code.
package uart_loader_pkg;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_FRM     = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CNT,
    ADDR_HI,
    ADDR_LO,
    DATA,
    CSUM
  } state_e;

endpackage

// File: rtl/uart_loader_timer.sv
// Idle-cycle counter for the frame loader; expired_o flags that the
// count has reached TIMEOUT_CYC-1 and it stops there until cleared.
module uart_loader_timer #(
  parameter int TIMEOUT_CYC = 100_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count_q;

  assign expired_o = (count_q == LIMIT);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (!expired_o) begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_frame_loader.sv
// Parses framed load commands popped from the UART byte FIFO and drives a
// word-wide memory write port, reporting per-frame completion or error.
module uart_frame_loader
  import uart_loader_pkg::*;
#(
  parameter int         ADDR_W      = 16,
  parameter int         TIMEOUT_CYC = 100_000,
  parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE
) (
  input  logic              clk_rx,
  input  logic              rst_clk_rx,
  input  logic [7:0]        rx_data,
  input  logic              rx_data_rdy,
  input  logic              frm_err,
  output logic              read_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code
);

  state_e            state_q;
  logic [8:0]        words_q;
  logic [7:0]        addr_hi_q;
  logic [ADDR_W-1:0] addr_q;
  logic [23:0]       word_q;
  logic [31:0]       word_d;
  logic [1:0]        idx_q;
  logic [7:0]        csum_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              load_done_q;
  logic              load_err_q;
  logic [1:0]        err_code_q;
  logic              expired;
  logic              timer_clear;

  // The FIFO is never stalled: every available byte is popped.
  assign read_en     = rx_data_rdy & rst_clk_rx;
  assign word_d      = {word_q, rx_data};
  assign timer_clear = (state_q == IDLE) | read_en;

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);
  assign load_done = load_done_q;
  assign load_err  = load_err_q;
  assign err_code  = err_code_q;

  uart_loader_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk_i    (clk_rx),
    .rst_ni   (rst_clk_rx),
    .clear_i  (timer_clear),
    .expired_o(expired)
  );

  always_ff @(posedge clk_rx) begin
    if (!rst_clk_rx) begin
      state_q     <= IDLE;
      words_q     <= '0;
      addr_hi_q   <= '0;
      addr_q      <= '0;
      word_q      <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      mem_we_q    <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      // Aborts outrank byte processing; a byte popped alongside frm_err is dropped.
      if (state_q != IDLE && frm_err) begin
        load_err_q <= 1'b1;
        err_code_q <= ERR_FRM;
        state_q    <= IDLE;
      end else if (state_q != IDLE && expired) begin
        load_err_q <= 1'b1;
        err_code_q <= ERR_TIMEOUT;
        state_q    <= IDLE;
      end else if (read_en) begin
        case (state_q)
          IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state_q <= CNT;
              idx_q   <= '0;
            end
          end
          CNT: begin
            words_q <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            csum_q  <= rx_data;
            state_q <= ADDR_HI;
          end
          ADDR_HI: begin
            addr_hi_q <= rx_data;
            csum_q    <= csum_q ^ rx_data;
            state_q   <= ADDR_LO;
          end
          ADDR_LO: begin
            addr_q  <= ADDR_W'({addr_hi_q, rx_data});
            csum_q  <= csum_q ^ rx_data;
            state_q <= DATA;
          end
          DATA: begin
            word_q <= word_d[23:0];
            idx_q  <= idx_q + 2'd1;
            csum_q <= csum_q ^ rx_data;
            if (idx_q == 2'd3) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= addr_q;
              mem_wdata_q <= word_d;
              addr_q      <= addr_q + ADDR_W'(1);
              words_q     <= words_q - 9'd1;
              if (words_q == 9'd1) begin
                state_q <= CSUM;
              end
            end
          end
          CSUM: begin
            if (rx_data == csum_q) begin
              load_done_q <= 1'b1;
            end else begin
              load_err_q <= 1'b1;
              err_code_q <= ERR_CSUM;
            end
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_frame_loader.md
# uart_frame_loader

Downstream consumer of the UART receiver's byte FIFO. Pops received bytes, parses framed load commands (sync byte, word count, start address, big-endian 32-bit words, XOR checksum) and drives a word-wide memory write port used to load instruction/data memory over the serial link. It reports completion and error status for each frame.

## Interface
- `ADDR_W`, 16: width of `mem_addr`. The 16-bit frame address is truncated or zero-extended to this width.
- `TIMEOUT_CYC`, 100_000: number of idle `clk_rx` cycles allowed between bytes inside a frame before the frame is aborted.
- `SYNC_BYTE`, 8'hA5: frame start marker.

Ports:
- `clk_rx`  in  1  system clock.
- `rst_clk_rx`  in  1  reset, synchronous to `clk_rx`, active-low.
- `rx_data`  in  8  FIFO head byte; first-word-fall-through, valid while `rx_data_rdy` is high.
- `rx_data_rdy`  in  1  FIFO not empty.
- `frm_err`  in  1  UART stop-bit error flag.
- `read_en`  out  1  pops one FIFO entry; combinational, equals `rx_data_rdy` while out of reset.
- `mem_we`  out  1  one-cycle write strobe.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  32  write data.
- `busy`  out  1  a frame is in progress (state other than IDLE).
- `load_done`  out  1  one-cycle pulse: frame complete with a good checksum.
- `load_err`  out  1  one-cycle pulse: frame aborted or bad checksum.
- `err_code`  out  2  held from the last error: 01 checksum, 10 timeout, 11 frm_err.

## Operation
- A byte is accepted in every cycle where `read_en` is high, so the block consumes at most 1 byte/cycle and never stalls the FIFO.
- Frame format: SYNC, CNT (N words, 0 means 256), ADDR_HI, ADDR_LO, then N×4 data bytes (MSB first), then CSUM.
- CSUM must equal the XOR of CNT, ADDR_HI, ADDR_LO and every data byte. SYNC is excluded.
- States and transitions:
  - IDLE: a byte equal to SYNC goes to CNT; any other byte is discarded and the state stays IDLE.
  - CNT → ADDR_HI → ADDR_LO → DATA, one accepted byte each.
  - DATA: a 2-bit byte index shifts bytes into a 32-bit word register. On the 4th byte, issue a write and decrement the word counter (9 bits). After the last word, go to CSUM.
  - CSUM: on match, pulse `load_done`; otherwise pulse `load_err` with code 01. Return to IDLE in both cases.
- Write address: the first word goes to the frame address. Each following word goes to the previous address + 1, wrapping modulo 2^ADDR_W.
- Words already written stay written even if the checksum later fails. Error handling is the host's responsibility.
- Abort conditions (checked in any state other than IDLE):
  - `frm_err` high → `load_err`, code 11, state IDLE. The byte in the same cycle is discarded.
  - Timeout counter reaches TIMEOUT_CYC−1 → `load_err`, code 10, state IDLE.
  - If both occur in the same cycle, `frm_err` wins.
- `frm_err` in IDLE is ignored.
- Timeout counter: cleared on every accepted byte and held at 0 in IDLE.

## Timing
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `load_done`=0, `load_err`=0, `err_code`=00, state IDLE. `read_en` is 0 during reset.
- `mem_we`, `mem_addr` and `mem_wdata` are registered. They are valid one cycle after the 4th byte of a word is accepted, and `mem_we` is high for exactly one cycle.
- `load_done` / `load_err` are registered and appear one cycle after the CSUM byte, or one cycle after the abort condition. `err_code` updates in the same cycle as `load_err`.
- `busy` rises the cycle after SYNC is accepted and falls in the same cycle as the `load_done` / `load_err` pulse.
- Back-to-back frames: a SYNC byte arriving the cycle after CSUM is accepted normally.
- Reset asserted mid-frame: everything returns to reset values on the next edge. No partial write or status pulse is emitted.
- Minimum frame length is 9 bytes (N=1), giving at least 9 cycles from SYNC to `load_done`.

## Structure
- Shared package `uart_loader_pkg` holds:
  - SYNC_BYTE default
  - state encoding (IDLE, CNT, ADDR_HI, ADDR_LO, DATA, CSUM)
  - error-code constants ERR_CSUM=2'b01, ERR_TIMEOUT=2'b10, ERR_FRM=2'b11
- One sub-module, `uart_loader_timer`: a clearable idle-cycle counter with width $clog2(TIMEOUT_CYC) and an `expired` output. Everything else lives in the top FSM.

## Test plan
- Frame A5 01 00 10 DE AD BE EF CSUM=(01^00^10^DE^AD^BE^EF) → one write at addr 0x0010, data 0xDEADBEEF; `load_done` pulses; `err_code` stays 00.
- CNT=00, addr FFFF, 256 words of incrementing data, ADDR_W=16 → 256 writes, address wraps FFFF→0000→…→00FE; `load_done` pulses once.
- Same as the first frame but CSUM off by one → write occurs, then `load_err` with code 01 and no `load_done`.
- Bytes 00 13 A5 02 00 00 followed by a gap of TIMEOUT_CYC cycles → leading garbage ignored, no write, `load_err` code 10, `busy` falls.
- `frm_err` pulsed during the 2nd data byte → `load_err` code 11, no write. A following good frame then completes normally.
- `rst_clk_rx` driven low for one cycle after the 3rd data byte → no `mem_we`; `busy`=0; the next frame loads correctly.
